stutter_scheduler: RTL and testbench



---
 rtl/stutter_sched_pkg.sv | 29 ++
 rtl/step_tracker.sv | 61 ++++++
 rtl/stutter_scheduler.sv | 128 ++++++++++++
 tb/tb_stutter_scheduler.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/stutter_sched_pkg.sv
// Shared types and defaults for the stutter scheduler and its step trackers.
package stutter_sched_pkg;

  localparam int unsigned STEP_W_DEF = 3;

  typedef enum logic [1:0] {
    LOCKSTEP = 2'd0,
    SEQ      = 2'd1,
    FREE     = 2'd2
  } sched_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  // Map the raw mode input onto a policy; the unused encoding 3 runs as FREE.
  function automatic sched_mode_e decode_mode(input logic [1:0] raw);
    sched_mode_e m;
    case (raw)
      2'd0:    m = LOCKSTEP;
      2'd1:    m = SEQ;
      default: m = FREE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/step_tracker.sv
// Per-block step counter: saturates at STEPS and turns eligibility plus the
// environment stutter request into an advance strobe.
// Optional: define FAIRNESS_EN to force an advance after MAX_STALL
// consecutive honoured stutters.
module step_tracker import stutter_sched_pkg::*; #(
  parameter int unsigned STEP_W    = STEP_W_DEF,
  parameter int unsigned STEPS     = 6
`ifdef FAIRNESS_EN
  , parameter int unsigned MAX_STALL = 7
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              eligible,
  input  logic              ext_stutter,
  output logic              adv,
  output logic [STEP_W-1:0] step,
  output logic              complete
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS);

  assign complete = (step == LAST_STEP);

`ifdef FAIRNESS_EN
  localparam int unsigned        STALL_W   = $clog2(MAX_STALL + 1);
  localparam logic [STALL_W-1:0] STALL_TOP = STALL_W'(MAX_STALL);

  logic [STALL_W-1:0] stall;
  logic               force_adv;

  assign force_adv = (stall == STALL_TOP);
  assign adv       = eligible && !complete && (!ext_stutter || force_adv);

  // Count consecutive honoured stutters; any advance or gap restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      stall <= '0;
    end else if (eligible && !complete && ext_stutter && !force_adv) begin
      stall <= stall + STALL_W'(1);
    end else begin
      stall <= '0;
    end
  end
`else
  assign adv = eligible && !complete && !ext_stutter;
`endif

  // Saturating step counter; adv is already gated by complete.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step <= '0;
    end else if (clear) begin
      step <= '0;
    end else if (adv) begin
      step <= step + STEP_W'(1);
    end
  end

endmodule

// File: rtl/stutter_scheduler.sv
// Drives the stutter inputs of a source/target codeblock pair under a
// LOCKSTEP, SEQ or FREE alignment policy, honouring environment stutters.
// Optional: define FAIRNESS_EN to bound consecutive environment stutters.
module stutter_scheduler import stutter_sched_pkg::*; #(
  parameter int unsigned STEP_W    = STEP_W_DEF,
  parameter int unsigned A_STEPS   = 6,
  parameter int unsigned B_STEPS   = 6,
  parameter int unsigned MAX_STALL = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              ext_stutter_a,
  input  logic              ext_stutter_b,
  output logic              stutter_a,
  output logic              stutter_b,
  output logic [STEP_W-1:0] step_a,
  output logic [STEP_W-1:0] step_b,
  output logic              busy,
  output logic              done
);

  // Parameter sanity: terminal steps must be representable, stall bound nonzero.
  if (A_STEPS >= (1 << STEP_W) || B_STEPS >= (1 << STEP_W)) begin : g_bad_steps
    $error("A_STEPS/B_STEPS do not fit in STEP_W bits");
  end
  if (MAX_STALL == 0) begin : g_bad_stall
    $error("MAX_STALL must be nonzero");
  end

  localparam logic [STEP_W-1:0] A_PENULT = STEP_W'(A_STEPS - 1);
  localparam logic [STEP_W-1:0] B_PENULT = STEP_W'(B_STEPS - 1);

  sched_state_e state, state_nxt;
  sched_mode_e  mode_q;
  logic         launch;
  logic         comp_a, comp_b;
  logic         adv_a, adv_b;
  logic         elig_a, elig_b;
  logic         ext_a_eff, ext_b_eff;
  logic         lock_both;
  logic         fin_a, fin_b;

  // State register and policy latch; a run launch relatches the mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      mode_q <= FREE;
    end else begin
      state <= state_nxt;
      if (launch) begin
        mode_q <= decode_mode(mode);
      end
    end
  end

  // Policy: which blocks may advance and which stutter request each one sees.
  always_comb begin
    lock_both = (mode_q == LOCKSTEP) && !comp_a && !comp_b;
    elig_a    = (state == RUN);
    elig_b    = (state == RUN) && ((mode_q != SEQ) || comp_a);
    ext_a_eff = lock_both ? (ext_stutter_a || ext_stutter_b) : ext_stutter_a;
    ext_b_eff = lock_both ? (ext_stutter_a || ext_stutter_b) : ext_stutter_b;
  end

  // Next-state: leave RUN on the edge of the final advance.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    fin_a     = comp_a || (adv_a && (step_a == A_PENULT));
    fin_b     = comp_b || (adv_b && (step_b == B_PENULT));
    case (state)
      IDLE, DONE: begin
        if (start) begin
          launch    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (fin_a && fin_b) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  step_tracker #(
    .STEP_W    (STEP_W),
    .STEPS     (A_STEPS)
`ifdef FAIRNESS_EN
    , .MAX_STALL (MAX_STALL)
`endif
  ) u_track_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (launch),
    .eligible    (elig_a),
    .ext_stutter (ext_a_eff),
    .adv         (adv_a),
    .step        (step_a),
    .complete    (comp_a)
  );

  step_tracker #(
    .STEP_W    (STEP_W),
    .STEPS     (B_STEPS)
`ifdef FAIRNESS_EN
    , .MAX_STALL (MAX_STALL)
`endif
  ) u_track_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (launch),
    .eligible    (elig_b),
    .ext_stutter (ext_b_eff),
    .adv         (adv_b),
    .step        (step_b),
    .complete    (comp_b)
  );

  assign stutter_a = !adv_a;
  assign stutter_b = !adv_b;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_stutter_scheduler.sv
// Directed bench for stutter_scheduler: each cycle's expected outputs are
// queued as the inputs are driven and checked mid-cycle on the falling edge.
module tb_stutter_scheduler;

  localparam int unsigned SW = 3;

  typedef struct packed {
    logic          sa;
    logic          sb;
    logic [SW-1:0] a;
    logic [SW-1:0] b;
    logic          busy;
    logic          done;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    mode;
  logic          ext_a;
  logic          ext_b;
  logic          stutter_a;
  logic          stutter_b;
  logic [SW-1:0] step_a;
  logic [SW-1:0] step_b;
  logic          busy;
  logic          done;

  int   n_assert = 0;
  int   n_fail   = 0;
  obs_t sb_q[$];

  always #5 clk = ~clk;

  stutter_scheduler #(
    .STEP_W    (SW),
    .A_STEPS   (6),
    .B_STEPS   (6),
    .MAX_STALL (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .mode          (mode),
    .ext_stutter_a (ext_a),
    .ext_stutter_b (ext_b),
    .stutter_a     (stutter_a),
    .stutter_b     (stutter_b),
    .step_a        (step_a),
    .step_b        (step_b),
    .busy          (busy),
    .done          (done)
  );

  function automatic obs_t mk(input logic sa, input logic sb, input int a,
                              input int b, input logic bz, input logic dn);
    obs_t o;
    o.sa   = sa;
    o.sb   = sb;
    o.a    = SW'(a);
    o.b    = SW'(b);
    o.busy = bz;
    o.done = dn;
    return o;
  endfunction

  // Drive one cycle of inputs, queue its expectation, check at the falling edge.
  task automatic cyc(input logic st, input logic [1:0] md, input logic ea,
                     input logic eb, input obs_t e, input string tag);
    obs_t got;
    obs_t want;
    start = st;
    mode  = md;
    ext_a = ea;
    ext_b = eb;
    sb_q.push_back(e);
    @(negedge clk);
    got.sa   = stutter_a;
    got.sb   = stutter_b;
    got.a    = step_a;
    got.b    = step_b;
    got.busy = busy;
    got.done = done;
    want = sb_q.pop_front();
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got sa=%b sb=%b a=%0d b=%0d busy=%b done=%b, expected sa=%b sb=%b a=%0d b=%0d busy=%b done=%b",
             tag, got.sa, got.sb, got.a, got.b, got.busy, got.done,
             want.sa, want.sb, want.a, want.b, want.busy, want.done);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 2'd0;
    ext_a = 1'b0;
    ext_b = 1'b0;
    @(posedge clk);
    #1;
    cyc(0, 2'd0, 0, 0, mk(1, 1, 0, 0, 0, 0), "reset");
    rst_n = 1'b1;

    // FREE, no stutters; a start mid-run with mode SEQ must be ignored.
    cyc(1, 2'd2, 0, 0, mk(1, 1, 0, 0, 0, 0), "free launch");
    for (int k = 1; k <= 6; k++) begin
      cyc((k == 3), (k == 3) ? 2'd1 : 2'd2, 0, 0, mk(0, 0, k - 1, k - 1, 1, 0),
          $sformatf("free c%0d", k));
    end

    // LOCKSTEP relaunched from DONE; A's request in cycles 2-3 holds both.
    cyc(1, 2'd0, 0, 0, mk(1, 1, 6, 6, 0, 1), "free done");
    cyc(0, 2'd0, 0, 0, mk(0, 0, 0, 0, 1, 0), "lock c1");
    cyc(0, 2'd0, 1, 0, mk(1, 1, 1, 1, 1, 0), "lock c2");
    cyc(0, 2'd0, 1, 0, mk(1, 1, 1, 1, 1, 0), "lock c3");
    for (int k = 4; k <= 8; k++) begin
      cyc(0, 2'd0, 0, 0, mk(0, 0, k - 3, k - 3, 1, 0), $sformatf("lock c%0d", k));
    end

    // SEQ from DONE: B held until A completes, then B runs alone.
    cyc(1, 2'd1, 0, 0, mk(1, 1, 6, 6, 0, 1), "lock done");
    for (int k = 1; k <= 12; k++) begin
      if (k <= 6) cyc(0, 2'd1, 0, 0, mk(0, 1, k - 1, 0, 1, 0), $sformatf("seq c%0d", k));
      else        cyc(0, 2'd1, 0, 0, mk(1, 0, 6, k - 7, 1, 0), $sformatf("seq c%0d", k));
    end

    // Mode 3 runs as FREE: A stalled two cycles, B completes first and stays held.
    cyc(1, 2'd3, 0, 0, mk(1, 1, 6, 6, 0, 1), "seq done");
    cyc(0, 2'd3, 1, 0, mk(1, 0, 0, 0, 1, 0), "m3 c1");
    cyc(0, 2'd3, 1, 0, mk(1, 0, 0, 1, 1, 0), "m3 c2");
    for (int k = 3; k <= 6; k++) begin
      cyc(0, 2'd3, 0, 0, mk(0, 0, k - 3, k - 1, 1, 0), $sformatf("m3 c%0d", k));
    end
    cyc(0, 2'd3, 0, 0, mk(0, 1, 4, 6, 1, 0), "m3 c7");
    cyc(0, 2'd3, 0, 0, mk(0, 1, 5, 6, 1, 0), "m3 c8");

    // Reset mid-RUN at step 3 returns to IDLE with cleared counters.
    cyc(1, 2'd2, 0, 0, mk(1, 1, 6, 6, 0, 1), "m3 done");
    for (int k = 1; k <= 3; k++) begin
      cyc(0, 2'd2, 0, 0, mk(0, 0, k - 1, k - 1, 1, 0), $sformatf("rst run c%0d", k));
    end
    rst_n = 1'b0;
    cyc(0, 2'd2, 0, 0, mk(0, 0, 3, 3, 1, 0), "rst asserted");
    rst_n = 1'b1;
    cyc(0, 2'd0, 0, 0, mk(1, 1, 0, 0, 0, 0), "rst idle");

`ifdef FAIRNESS_EN
    // Held A stutter: every 4th cycle A is forced forward, B unaffected.
    cyc(1, 2'd2, 1, 0, mk(1, 1, 0, 0, 0, 0), "fair launch");
    for (int k = 1; k <= 24; k++) begin
      cyc(0, 2'd2, 1, 0,
          mk((k % 4) != 0, k > 6, (k - 1) / 4, (k > 6) ? 6 : k - 1, 1, 0),
          $sformatf("fair c%0d", k));
    end
    cyc(0, 2'd2, 1, 0, mk(1, 1, 6, 6, 0, 1), "fair done");
`else
    // Held A stutter without fairness: A never moves, run stays busy.
    cyc(1, 2'd2, 1, 0, mk(1, 1, 0, 0, 0, 0), "hold launch");
    for (int k = 1; k <= 10; k++) begin
      cyc(0, 2'd2, 1, 0, mk(1, k > 6, 0, (k > 6) ? 6 : k - 1, 1, 0),
          $sformatf("hold c%0d", k));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
